// File: rtl/cdb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cdb_arbiter_pkg
// Purpose : Shared sizes, types and helpers for the CDB complete stage.
//           Holds the FU slot count, the ROB tag and data widths, the CDB
//           broadcast packet, the fu_done vector type and the round-robin
//           slot-advance helper.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package cdb_arbiter_pkg;

  localparam int N_SRC  = 6;                   // FU result slots, indexed 1..N_SRC
  localparam int TAG_W  = 5;                   // ROB tag width
  localparam int DATA_W = 32;                  // result value width
  localparam int SLOT_W = $clog2(N_SRC + 1);   // width of a slot index (RS entry id)

  typedef logic [SLOT_W-1:0] rs_tag_t;         // slot index, 1..N_SRC
  typedef logic [TAG_W-1:0]  rob_tag_t;
  typedef logic [DATA_W-1:0] data_t;

  // Tag 0 is reserved to mean "no tag".
  localparam rob_tag_t c_zero_reg   = '0;
  localparam rs_tag_t  c_first_slot = rs_tag_t'(1);
  localparam rs_tag_t  c_last_slot  = rs_tag_t'(N_SRC);

  typedef struct packed {
    logic     valid;
    rob_tag_t rob_tag;
    data_t    v;
  } cdb_packet_t;

  typedef logic [N_SRC:0] fu_done_packet_t;    // bit 0 unused

  typedef enum logic [0:0] {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

  // Next slot in round-robin order; wraps N_SRC back to 1 (slot 0 is never used).
  function automatic rs_tag_t next_slot(input rs_tag_t s);
    return (s == c_last_slot) ? c_first_slot : s + rs_tag_t'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cdb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : cdb_arbiter_if
// Purpose : Bundle between the functional units / CDB consumers and the CDB
//           arbiter.
//   fu_valid       FU -> arb   slot i offers a result (bit 0 ignored)
//   fu_rob_tag     FU -> arb   ROB tag per slot
//   fu_value       FU -> arb   result value per slot
//   fu_ready       arb -> FU   slot i can accept this cycle (bit 0 tied 0)
//   cdb_packet     arb -> all  registered {valid, rob_tag, v} broadcast
//   fu_done_packet arb -> RS   one-hot slot whose result is on the CDB
//   master = FU / consumer side, slave = arbiter.
// Revision: 1.0 - initial release
// ============================================================================
interface cdb_arbiter_if;
  import cdb_arbiter_pkg::*;

  logic [N_SRC:0]             fu_valid;
  logic [N_SRC:0][TAG_W-1:0]  fu_rob_tag;
  logic [N_SRC:0][DATA_W-1:0] fu_value;
  logic [N_SRC:0]             fu_ready;
  cdb_packet_t                cdb_packet;
  fu_done_packet_t            fu_done_packet;

  modport master (
    output fu_valid, fu_rob_tag, fu_value,
    input  fu_ready, cdb_packet, fu_done_packet
  );

  modport slave (
    input  fu_valid, fu_rob_tag, fu_value,
    output fu_ready, cdb_packet, fu_done_packet
  );

endinterface
`default_nettype wire

// File: rtl/cdb_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module  : cdb_rr_arbiter
// Purpose : Purely combinational round-robin picker over slots 1..N_SRC.
//           Grants the first requesting slot found searching ptr, ptr+1, ...
//           wrapping N_SRC -> 1. At most one grant.
//   req         in   [N_SRC:1]  slot has a buffered result
//   ptr         in   SLOT_W     first slot to consider (1..N_SRC)
//   grant       out  [N_SRC:1]  one-hot grant
//   grant_valid out  1          some slot was granted
// Revision: 1.0 - initial release
// ============================================================================
module cdb_rr_arbiter
  import cdb_arbiter_pkg::*;
(
  input  logic [N_SRC:1] req,
  input  rs_tag_t        ptr,
  output logic [N_SRC:1] grant,
  output logic           grant_valid
);

  rs_tag_t w_idx;

  // Walk the ring starting at ptr; the first hit wins and later hits are masked.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    w_idx       = ptr;
    for (int k = 0; k < N_SRC; k++) begin
      if (!grant_valid && req[w_idx]) begin
        grant[w_idx] = 1'b1;
        grant_valid  = 1'b1;
      end
      w_idx = next_slot(w_idx);
    end
  end

endmodule
`default_nettype wire

// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : cdb_arbiter
// Purpose : Complete stage downstream of the RS-issued functional units.
//           Buffers one finished result per FU slot and broadcasts one per
//           cycle on the single CDB, picked round-robin. Also pulses the
//           fu_done bit that frees the matching RS entry.
//   clock   in   1      single clock, all state on posedge
//   reset   in   1      synchronous, active-low
//   squash  in   1      full pipeline flush
//   bus     slave       FU handshake, cdb_packet, fu_done_packet
// Revision: 1.0 - initial release
// ============================================================================
module cdb_arbiter
  import cdb_arbiter_pkg::*;
(
  input  logic         clock,
  input  logic         reset,
  input  logic         squash,
  cdb_arbiter_if.slave bus
);

  slot_state_t     r_state [1:N_SRC];
  rob_tag_t        r_tag   [1:N_SRC];
  data_t           r_value [1:N_SRC];
  rs_tag_t         r_rr_ptr;
  cdb_packet_t     r_cdb;
  fu_done_packet_t r_fu_done;

  logic [N_SRC:1]  w_full;
  logic [N_SRC:1]  w_grant;
  logic            w_grant_valid;
  logic [N_SRC:0]  w_ready;
  logic [N_SRC:0]  w_accept;
  rs_tag_t         w_gnt_idx;
  rob_tag_t        w_gnt_tag;
  data_t           w_gnt_value;

  // Slot 0 of the FU bundle does not exist.
  logic w_unused_slot0;
  assign w_unused_slot0 = ^{bus.fu_valid[0], bus.fu_rob_tag[0], bus.fu_value[0]};

  always_comb begin
    w_full = '0;
    for (int i = 1; i <= N_SRC; i++) begin
      w_full[i] = (r_state[i] == SLOT_FULL);
    end
  end

  cdb_rr_arbiter u_rr (
    .req         (w_full),
    .ptr         (r_rr_ptr),
    .grant       (w_grant),
    .grant_valid (w_grant_valid)
  );

  // Ready depends only on registered state (full flags and the grant derived
  // from them), so there is no combinational path from fu_valid to fu_ready.
  // A slot being granted this cycle frees up at the edge and can refill at once.
  always_comb begin
    w_ready  = '0;
    w_accept = '0;
    for (int i = 1; i <= N_SRC; i++) begin
      w_ready[i]  = !w_full[i] || w_grant[i];
      w_accept[i] = bus.fu_valid[i] && w_ready[i];
    end
  end

  // One-hot grant -> index and payload mux.
  always_comb begin
    w_gnt_idx   = c_first_slot;
    w_gnt_tag   = c_zero_reg;
    w_gnt_value = '0;
    for (int i = 1; i <= N_SRC; i++) begin
      if (w_grant[i]) begin
        w_gnt_idx   = rs_tag_t'(i);
        w_gnt_tag   = r_tag[i];
        w_gnt_value = r_value[i];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 1; i <= N_SRC; i++) begin
        r_state[i] <= SLOT_EMPTY;
        r_tag[i]   <= c_zero_reg;
        r_value[i] <= '0;
      end
      r_rr_ptr  <= c_first_slot;
      r_cdb     <= '{valid: 1'b0, rob_tag: c_zero_reg, v: '0};
      r_fu_done <= '0;
    end else if (squash) begin
      // Everything buffered or arriving this cycle is dropped; nothing is granted.
      for (int i = 1; i <= N_SRC; i++) begin
        r_state[i] <= SLOT_EMPTY;
      end
      r_rr_ptr  <= c_first_slot;
      r_cdb     <= '{valid: 1'b0, rob_tag: c_zero_reg, v: '0};
      r_fu_done <= '0;
    end else begin
      // Accept takes precedence over the grant's release, so a slot that is
      // drained and refilled on the same edge stays FULL with the new result.
      for (int i = 1; i <= N_SRC; i++) begin
        if (w_accept[i]) begin
          r_state[i] <= SLOT_FULL;
          r_tag[i]   <= bus.fu_rob_tag[i];
          r_value[i] <= bus.fu_value[i];
        end else if (w_grant[i]) begin
          r_state[i] <= SLOT_EMPTY;
        end
      end

      if (w_grant_valid) begin
        r_cdb     <= '{valid: 1'b1, rob_tag: w_gnt_tag, v: w_gnt_value};
        r_fu_done <= {w_grant, 1'b0};
        r_rr_ptr  <= next_slot(w_gnt_idx);
      end else begin
        r_cdb     <= '{valid: 1'b0, rob_tag: c_zero_reg, v: '0};
        r_fu_done <= '0;
      end
    end
  end

  assign bus.fu_ready       = w_ready;
  assign bus.cdb_packet     = r_cdb;
  assign bus.fu_done_packet = r_fu_done;

endmodule
`default_nettype wire
